// File: rtl/wb_datapath_regs_if.sv
// Wishbone classic slave-side bundle for the datapath register window.
// The SoC side drives the request; the register block returns ack and read data.
interface wb_datapath_regs_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic        ack;
    logic [31:0] dat_r;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  ack, dat_r
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output ack, dat_r
    );
endinterface

// File: rtl/wb_datapath_regs.sv
// Wishbone-mapped 8 x 32-bit register file with a three-stage add/sub engine,
// status/result readback and a level completion interrupt.
module wb_datapath_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned NREGS     = 8
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    wb_datapath_regs_if.slave         wbs,
    output logic                      irq_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StWb   = 2'd2;

    localparam logic [5:0] OffCtrl   = 6'h00;
    localparam logic [5:0] OffStatus = 6'h01;
    localparam logic [5:0] OffResult = 6'h02;

    logic        ack_q;
    logic [31:0] dat_q;
    logic        wr_q;
    logic [5:0]  woff_q;
    logic [3:0]  wsel_q;
    logic [31:0] wdat_q;

    logic [1:0]  state_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        op_q;
    logic [2:0]  rd_q;
    logic [31:0] res_q;
    logic        flag_q;

    logic [31:0] result_q;
    logic        carry_q;
    logic        done_q;
    logic        overrun_q;
    logic        irq_en_q;
    logic [7:0]  count_q;
    logic        irq_q;
    logic [31:0] rf_q [NREGS];

    logic        hit;
    logic [5:0]  off;
    logic        req;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] wmask;
    logic [31:0] wdat_m;
    logic        commit;
    logic        ctrl_wr;
    logic        status_wr;
    logic        rf_wr;
    logic [2:0]  widx;
    logic        start;
    logic [32:0] sum;

    assign hit  = (wbs.adr & 32'hFFFF_FF00) == BASE_ADDR;
    assign off  = wbs.adr[7:2];
    assign req  = wbs.cyc & wbs.stb & hit & ~ack_q;
    assign busy = state_q != StIdle;

    assign wbs.ack   = ack_q;
    assign wbs.dat_r = dat_q;
    assign irq_o     = irq_q;

    // Writes are latched at request time and applied during the ack cycle.
    assign wmask     = {{8{wsel_q[3]}}, {8{wsel_q[2]}}, {8{wsel_q[1]}}, {8{wsel_q[0]}}};
    assign wdat_m    = wdat_q & wmask;
    assign commit    = ack_q & wr_q;
    assign ctrl_wr   = commit && (woff_q == OffCtrl);
    assign status_wr = commit && (woff_q == OffStatus);
    assign rf_wr     = commit && (woff_q[5:3] == 3'b010);
    assign widx      = woff_q[2:0];
    assign start     = ctrl_wr & wdat_m[0];

    // Subtract as A + ~B + 1; the carry flag is then inverted into a borrow.
    assign sum = {1'b0, a_q} + {1'b0, (op_q ? ~b_q : b_q)} + {32'b0, op_q};

    always_comb begin
        rd_data = '0;
        if (off == OffCtrl) begin
            rd_data = {19'b0, irq_en_q, 12'b0};
        end else if (off == OffStatus) begin
            rd_data = {16'b0, count_q, 4'b0, overrun_q, carry_q, done_q, busy};
        end else if (off == OffResult) begin
            rd_data = result_q;
        end else if (off[5:3] == 3'b010) begin
            rd_data = rf_q[off[2:0]];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            wr_q      <= 1'b0;
            woff_q    <= '0;
            wsel_q    <= '0;
            wdat_q    <= '0;
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            rd_q      <= '0;
            res_q     <= '0;
            flag_q    <= 1'b0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            irq_en_q  <= 1'b0;
            count_q   <= '0;
            irq_q     <= 1'b0;
            rf_q      <= '{default: '0};
        end else begin
            ack_q <= req;
            wr_q  <= req & wbs.we;
            dat_q <= (req && !wbs.we) ? rd_data : 32'h0;
            if (req) begin
                woff_q <= off;
                wsel_q <= wbs.sel;
                wdat_q <= wbs.dat_w;
            end

            irq_q <= done_q & irq_en_q;

            if (ctrl_wr && wsel_q[1]) begin
                irq_en_q <= wdat_m[12];
            end
            if (start && busy) begin
                overrun_q <= 1'b1;
            end
            if (status_wr && wsel_q[0]) begin
                if (wdat_m[1]) done_q <= 1'b0;
                if (wdat_m[3]) overrun_q <= 1'b0;
            end

            // The datapath owns rd during write-back; a colliding bus write loses.
            if (rf_wr && widx != 3'd0 && !(state_q == StWb && widx == rd_q)) begin
                rf_q[widx] <= (rf_q[widx] & ~wmask) | wdat_m;
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= rf_q[wdat_m[7:5]];
                        b_q     <= rf_q[wdat_m[10:8]];
                        op_q    <= wdat_m[11];
                        rd_q    <= wdat_m[4:2];
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    res_q   <= sum[31:0];
                    flag_q  <= sum[32] ^ op_q;
                    state_q <= StWb;
                end
                StWb: begin
                    if (rd_q != 3'd0) begin
                        rf_q[rd_q] <= res_q;
                    end
                    result_q <= res_q;
                    carry_q  <= flag_q;
                    done_q   <= 1'b1;
                    count_q  <= count_q + 8'd1;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
